// File: rtl/x25519_recip_pkg.sv
// Shared types and the fixed addition-chain program for the X25519 field inversion z^(p-2).
// The program is a constant ROM indexed by step number.
package x25519_recip_pkg;

  localparam int unsigned FE_W = 264;
  typedef logic [FE_W-1:0] fe_t;

  typedef enum logic [3:0] {
    RegZ, RegZ2, RegZ9, RegZ11, RegR5, RegR10, RegR20, RegR50, RegR100, RegT, RegOut
  } regsel_t;

  localparam int unsigned NUM_REGS = 11;

  typedef enum logic {OpSq, OpMul} op_t;

  typedef struct packed {
    op_t         op;
    regsel_t     src_a;
    regsel_t     src_b;
    regsel_t     dst;
    logic [6:0]  count;
  } recip_step_t;

  localparam int unsigned RECIP_STEPS = 22;
  localparam int unsigned RECIP_MULTS = 265;

  // Squaring steps: intermediate results land in T, the last one in dst.
  localparam recip_step_t RECIP_PROGRAM [RECIP_STEPS] = '{
    '{OpSq,  RegZ,    RegZ,    RegZ2,   7'd1},
    '{OpSq,  RegZ2,   RegZ2,   RegT,    7'd2},
    '{OpMul, RegT,    RegZ,    RegZ9,   7'd1},
    '{OpMul, RegZ9,   RegZ2,   RegZ11,  7'd1},
    '{OpSq,  RegZ11,  RegZ11,  RegT,    7'd1},
    '{OpMul, RegT,    RegZ9,   RegR5,   7'd1},
    '{OpSq,  RegR5,   RegR5,   RegT,    7'd5},
    '{OpMul, RegT,    RegR5,   RegR10,  7'd1},
    '{OpSq,  RegR10,  RegR10,  RegT,    7'd10},
    '{OpMul, RegT,    RegR10,  RegR20,  7'd1},
    '{OpSq,  RegR20,  RegR20,  RegT,    7'd20},
    '{OpMul, RegT,    RegR20,  RegT,    7'd1},
    '{OpSq,  RegT,    RegT,    RegT,    7'd10},
    '{OpMul, RegT,    RegR10,  RegR50,  7'd1},
    '{OpSq,  RegR50,  RegR50,  RegT,    7'd50},
    '{OpMul, RegT,    RegR50,  RegR100, 7'd1},
    '{OpSq,  RegR100, RegR100, RegT,    7'd100},
    '{OpMul, RegT,    RegR100, RegT,    7'd1},
    '{OpSq,  RegT,    RegT,    RegT,    7'd50},
    '{OpMul, RegT,    RegR50,  RegT,    7'd1},
    '{OpSq,  RegT,    RegT,    RegT,    7'd5},
    '{OpMul, RegT,    RegZ11,  RegOut,  7'd1}
  };

  function automatic int unsigned step_idx(logic [4:0] s);
    return (32'(s) < RECIP_STEPS) ? 32'(s) : 32'd0;
  endfunction

  function automatic regsel_t step_src_a(logic [4:0] s);
    return RECIP_PROGRAM[step_idx(s)].src_a;
  endfunction

  function automatic regsel_t step_src_b(logic [4:0] s);
    return (RECIP_PROGRAM[step_idx(s)].op == OpSq) ? RECIP_PROGRAM[step_idx(s)].src_a
                                                   : RECIP_PROGRAM[step_idx(s)].src_b;
  endfunction

  function automatic regsel_t step_dst(logic [4:0] s);
    return RECIP_PROGRAM[step_idx(s)].dst;
  endfunction

  function automatic logic [6:0] step_count(logic [4:0] s);
    return RECIP_PROGRAM[step_idx(s)].count;
  endfunction

endpackage

// File: rtl/x25519_recip_if.sv
// Host-side start/result handshake plus the initiator side of the shared multiplier port.
interface x25519_recip_if;
  import x25519_recip_pkg::*;

  logic en;
  fe_t  din;
  logic busy;
  logic out_valid;
  fe_t  out;
  logic mult_en;
  fe_t  mult_a;
  fe_t  mult_b;
  logic mult_out_valid;
  fe_t  mult_out;

  modport slave (
    input  en, din, mult_out_valid, mult_out,
    output busy, out_valid, out, mult_en, mult_a, mult_b
  );

  modport master (
    output en, din, mult_out_valid, mult_out,
    input  busy, out_valid, out, mult_en, mult_a, mult_b
  );

endinterface

// File: rtl/x25519_recip.sv
// Field inversion z^(p-2) mod 2^255-19 by sequencing a shared multiplier through a fixed
// chain of 254 squarings and 11 multiplies; no arithmetic is done locally.
module x25519_recip
  import x25519_recip_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 1024
) (
  input logic            clk,
  input logic            rst,
  x25519_recip_if.slave  bus
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StDrain, StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic [4:0]      step_q, step_d;
  logic [6:0]      iter_q, iter_d;
  fe_t             rf_q [NUM_REGS];
  fe_t             rf_d [NUM_REGS];
  fe_t             mult_a_q, mult_a_d;
  fe_t             mult_b_q, mult_b_d;
  logic            out_valid_q, out_valid_d;

  logic            last_iter, last_step, drain_done;
  regsel_t         res_dst, a_sel, b_sel;

  assign last_iter  = iter_q == (step_count(step_q) - 7'd1);
  assign last_step  = step_q == 5'(RECIP_STEPS - 1);
  assign drain_done = drain_q == CntW'(DRAIN_CYCLES - 1);
  assign res_dst    = last_iter ? step_dst(step_q) : RegT;

  // Operands for the next multiply: either the next squaring of T or the next program step.
  always_comb begin
    if (last_iter) begin
      a_sel = step_src_a(step_q + 5'd1);
      b_sel = step_src_b(step_q + 5'd1);
    end else begin
      a_sel = RegT;
      b_sel = RegT;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StDrain;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A stale multiplier completion can arrive while draining; it is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDrain: if (drain_done) state_d = StIdle;
      StIdle:  if (bus.en) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.mult_out_valid) state_d = (last_iter && last_step) ? StIdle : StIssue;
      end
      default: state_d = StDrain;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy    = state_q != StIdle;
    bus.mult_en = state_q == StIssue;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = rf_q[RegOut];
  assign bus.mult_a    = mult_a_q;
  assign bus.mult_b    = mult_b_q;

  always_comb begin
    drain_d     = '0;
    step_d      = step_q;
    iter_d      = iter_q;
    rf_d        = rf_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StDrain: drain_d = drain_q + CntW'(1);
      StIdle: begin
        if (bus.en) begin
          rf_d[RegZ] = bus.din;
          step_d     = '0;
          iter_d     = '0;
          mult_a_d   = bus.din;
          mult_b_d   = bus.din;
        end
      end
      StWait: begin
        if (bus.mult_out_valid) begin
          rf_d[res_dst] = bus.mult_out;
          if (last_iter && last_step) begin
            out_valid_d = 1'b1;
          end else begin
            if (last_iter) begin
              step_d = step_q + 5'd1;
              iter_d = '0;
            end else begin
              iter_d = iter_q + 7'd1;
            end
            // Forward the fresh product when it is also the next source.
            mult_a_d = (a_sel == res_dst) ? bus.mult_out : rf_q[a_sel];
            mult_b_d = (b_sel == res_dst) ? bus.mult_out : rf_q[b_sel];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q     <= '0;
      step_q      <= '0;
      iter_q      <= '0;
      rf_q        <= '{default: '0};
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      drain_q     <= drain_d;
      step_q      <= step_d;
      iter_q      <= iter_d;
      rf_q        <= rf_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_x25519_recip.sv
// Drives x25519_recip against a fixed-latency modular multiplier model and compares each
// result with z^(p-2) mod p computed by plain square-and-multiply.
module tb_x25519_recip;
  import x25519_recip_pkg::*;

  localparam int unsigned Drain   = 1024;
  localparam int unsigned Lm      = 3;
  localparam int unsigned NMults  = 265;
  localparam int unsigned Lat     = NMults * (Lm + 1) + 1;
  localparam int unsigned Timeout = 2 * Lat;
  localparam logic [527:0] PW = (528'd1 << 255) - 528'd19;
  localparam fe_t P = (264'd1 << 255) - 264'd19;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_checks;
  int   n_mult_en;
  int   n_out_valid;

  x25519_recip_if bus ();

  x25519_recip #(.DRAIN_CYCLES(Drain)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic fe_t mulmod(input fe_t a, input fe_t b);
    logic [527:0] x;
    x = (528'(a) * 528'(b)) % PW;
    return x[263:0];
  endfunction

  function automatic fe_t inv_ref(input fe_t z);
    fe_t r;
    fe_t e;
    fe_t zz;
    r  = 264'd1;
    e  = P - 264'd2;
    zz = z % P;
    for (int i = 254; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, zz);
    end
    return r;
  endfunction

  function automatic fe_t rand_fe();
    fe_t v;
    v = '0;
    for (int i = 0; i < 9; i++) v = (v << 32) | fe_t'($urandom);
    return v;
  endfunction

  task automatic check(input string tag, input fe_t got, input fe_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mult_en) n_mult_en <= n_mult_en + 1;
    if (bus.out_valid) n_out_valid <= n_out_valid + 1;
  end

  // Multiplier model: no reset, result valid Lm cycles after mult_en, garbage otherwise.
  initial begin
    fe_t a;
    fe_t b;
    bus.mult_out_valid = 1'b0;
    bus.mult_out       = '0;
    forever begin
      @(negedge clk);
      if (bus.mult_en) begin
        a = bus.mult_a;
        b = bus.mult_b;
        repeat (Lm) @(posedge clk);
        #1;
        bus.mult_out       = mulmod(a, b);
        bus.mult_out_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_out_valid = 1'b0;
        bus.mult_out       = rand_fe();
      end
    end
  end

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (bus.busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, fe_t'(bus.busy), fe_t'(0));
  endtask

  // Starts a run at the current negedge and returns at the negedge where out_valid is seen.
  task automatic run(input string tag, input fe_t z, input int intr_at, input fe_t intr_din,
                     output fe_t res);
    int lat;
    int mc0;
    bit busy_ok;
    bit done;
    bit fired;
    bus.din = z;
    bus.en  = 1'b1;
    mc0     = n_mult_en;
    busy_ok = 1'b1;
    done    = 1'b0;
    fired   = 1'b0;
    @(negedge clk);
    bus.en = 1'b0;
    lat    = 1;
    while (lat <= Timeout) begin
      if (bus.out_valid) begin
        done = 1'b1;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (intr_at > 0 && !fired && (n_mult_en - mc0) >= intr_at) begin
        bus.din = intr_din;
        bus.en  = 1'b1;
        fired   = 1'b1;
      end else begin
        bus.en = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.en = 1'b0;
    check({tag, "_done"}, fe_t'(done), fe_t'(1));
    check({tag, "_latency"}, fe_t'(lat), fe_t'(Lat));
    check({tag, "_busy_during"}, fe_t'(busy_ok), fe_t'(1));
    check({tag, "_busy_drop"}, fe_t'(bus.busy), fe_t'(0));
    check({tag, "_mult_count"}, fe_t'(n_mult_en - mc0), fe_t'(NMults));
    res = bus.out;
  endtask

  initial begin
    fe_t res;
    fe_t res2;
    fe_t z;
    int  oc0;
    int  mc0;
    int  n;
    n_pass      = 0;
    n_checks    = 0;
    n_mult_en   = 0;
    n_out_valid = 0;
    bus.en      = 1'b0;
    bus.din     = '0;
    rst         = 1'b0;
    #1 rst      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", fe_t'(bus.busy), fe_t'(1));
    check("rst_out_valid", fe_t'(bus.out_valid), fe_t'(0));
    check("rst_out", bus.out, '0);
    check("rst_mult_en", fe_t'(bus.mult_en), fe_t'(0));
    check("rst_mult_a", bus.mult_a, '0);
    check("rst_mult_b", bus.mult_b, '0);
    rst = 1'b0;
    @(negedge clk);
    check("drain_busy", fe_t'(bus.busy), fe_t'(1));
    mc0 = n_mult_en;
    repeat (5) @(negedge clk);
    bus.din = 264'd7;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    wait_idle("drain", Drain + 20);
    repeat (3) @(negedge clk);
    check("drain_en_ignored", fe_t'(n_mult_en - mc0), fe_t'(0));

    oc0 = n_out_valid;
    run("one", 264'd1, 0, '0, res);
    check("one_out", res % P, 264'd1);
    repeat (4) @(negedge clk);
    check("one_pulses", fe_t'(n_out_valid - oc0), fe_t'(1));
    check("one_held", bus.out, res);

    run("two", 264'd2, 0, '0, res);
    check("two_out", res % P, (264'd1 << 254) - 264'd9);
    check("two_model", res % P, inv_ref(264'd2));
    repeat (2) @(negedge clk);

    run("nine", 264'd9, 0, '0, res);
    check("nine_model", res % P, inv_ref(264'd9));
    check("nine_prod", mulmod(264'd9, res), 264'd1);
    repeat (2) @(negedge clk);

    oc0 = n_out_valid;
    run("zero", 264'd0, 0, '0, res);
    check("zero_out", res, '0);
    repeat (4) @(negedge clk);
    check("zero_pulses", fe_t'(n_out_valid - oc0), fe_t'(1));

    for (int k = 0; k < 3; k++) begin
      z = rand_fe();
      run("rand", z, 0, '0, res);
      check("rand_model", res % P, inv_ref(z));
      repeat (2) @(negedge clk);
    end

    // Extra en while busy in step 10 must not disturb the run.
    z   = rand_fe();
    oc0 = n_out_valid;
    run("intr", z, 26, 264'd123, res);
    check("intr_model", res % P, inv_ref(z));
    mc0 = n_mult_en;
    repeat (10) @(negedge clk);
    check("intr_pulses", fe_t'(n_out_valid - oc0), fe_t'(1));
    check("intr_no_restart", fe_t'(n_mult_en - mc0), fe_t'(0));

    // Reset during step 14, then en during drain, then a clean run.
    z       = rand_fe();
    oc0     = n_out_valid;
    mc0     = n_mult_en;
    bus.din = z;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    n      = 0;
    while ((n_mult_en - mc0) < 60 && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", fe_t'((n_mult_en - mc0) >= 60), fe_t'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_drain_busy", fe_t'(bus.busy), fe_t'(1));
    mc0     = n_mult_en;
    bus.din = 264'd11;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    wait_idle("abort", Drain + 20);
    repeat (3) @(negedge clk);
    check("abort_en_ignored", fe_t'(n_mult_en - mc0), fe_t'(0));
    check("abort_no_out_valid", fe_t'(n_out_valid - oc0), fe_t'(0));
    run("three", 264'd3, 0, '0, res);
    check("three_model", res % P, inv_ref(264'd3));
    check("three_prod", mulmod(264'd3, res), 264'd1);
    repeat (2) @(negedge clk);

    // Back-to-back: second en in the same cycle as the first out_valid.
    z   = rand_fe();
    oc0 = n_out_valid;
    run("b2b_a", z, 0, '0, res);
    run("b2b_b", 264'd5, 0, '0, res2);
    check("b2b_a_model", res % P, inv_ref(z));
    check("b2b_b_model", res2 % P, inv_ref(264'd5));
    check("b2b_b_prod", mulmod(264'd5, res2), 264'd1);
    repeat (4) @(negedge clk);
    check("b2b_pulses", fe_t'(n_out_valid - oc0), fe_t'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
